// File: rtl/fp_mul_stream_pkg.sv
// -----------------------------------------------------------------------------
// fp_mul_stream_pkg
// Shared types and constants for the FP multiplier streaming controller.
//   FP_WIDTH             : width of an IEEE-754 single-precision word
//   fp32_t               : raw IEEE-754 single bit pattern
//   DEFAULT_MUL_LATENCY  : pipeline depth of the multiplier core
//   DEFAULT_FIFO_DEPTH   : default result FIFO size
//   ONE / ZERO           : handy FP32 constants
// -----------------------------------------------------------------------------
package fp_mul_stream_pkg;

    localparam int FP_WIDTH            = 32;
    localparam int DEFAULT_MUL_LATENCY = 4;
    localparam int DEFAULT_FIFO_DEPTH  = 8;

    typedef logic [FP_WIDTH-1:0] fp32_t;

    localparam fp32_t ONE  = 32'h3F80_0000;
    localparam fp32_t ZERO = 32'h0000_0000;

endpackage : fp_mul_stream_pkg

// File: rtl/fp_mul_result_fifo.sv
// -----------------------------------------------------------------------------
// fp_mul_result_fifo
// First-word fall-through result buffer. The producer guarantees it never
// writes when full, so there is no internal full check.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset (pointers and count only)
//   wr_en    : write wr_data at the next edge
//   wr_data  : result word to store
//   rd_en    : pop the head entry (ignored while empty)
//   rd_data  : head entry; forced to zero while empty
//   count    : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module fp_mul_result_fifo
    import fp_mul_stream_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  fp32_t                    wr_data,
    input  logic                     rd_en,
    output fp32_t                    rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fp32_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           not_empty;
    logic           do_rd;

    assign not_empty = (count != '0);
    assign do_rd     = rd_en & not_empty;
    assign rd_data   = not_empty ? mem[rd_ptr] : ZERO;

    // NOTE: storage is deliberately left out of reset; the count alone decides
    // which entries are meaningful, so resetting the array only costs routing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so they wrap for free.
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule : fp_mul_result_fifo

// File: rtl/fp_mul_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fp_mul_stream_ctrl
// Streaming wrapper around a free-running, fixed-latency FP32 multiplier core.
// Operand pairs are accepted over a valid/ready handshake, tracked through the
// core with a valid shift register, and the products are buffered in a FIFO.
// A credit count (in-flight + buffered) bounds acceptance so downstream
// backpressure can never drop a product.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   s_valid/s_ready     : operand handshake
//   s_a, s_b            : FP32 operands
//   m_valid/m_ready     : result handshake
//   m_result            : FP32 product (zero while no result is held)
//   mul_ena, mul_clr    : core enable (always 1) and clear (= ~rst_n)
//   mul_ay, mul_az      : core operands (zero in cycles without acceptance)
//   mul_result          : core product, MUL_LATENCY cycles after sampling
// -----------------------------------------------------------------------------
module fp_mul_stream_ctrl
    import fp_mul_stream_pkg::*;
#(
    parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  s_valid,
    output logic  s_ready,
    input  fp32_t s_a,
    input  fp32_t s_b,
    output logic  m_valid,
    input  logic  m_ready,
    output fp32_t m_result,
    output logic  mul_ena,
    output logic  mul_clr,
    output fp32_t mul_ay,
    output fp32_t mul_az,
    input  fp32_t mul_result
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // The FIFO must absorb everything in flight plus one slot of slack so
    // that full-rate streaming never throttles s_ready.
    if ((MUL_LATENCY < 1) ||
        (FIFO_DEPTH < MUL_LATENCY + 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_param_check
        $error("fp_mul_stream_ctrl: FIFO_DEPTH must be a power of 2 and >= MUL_LATENCY+2");
    end

    logic [MUL_LATENCY-1:0] vld_sr;
    logic [CW-1:0]          inflight_cnt;
    logic [CW-1:0]          fifo_cnt;
    logic [CW:0]            credit_used;
    logic                   acc;
    logic                   capture;
    logic                   pop;

    // Credits come from registered counters only: m_ready has no
    // combinational path to s_ready, so a slot freed by a pop is offered
    // one cycle later.
    assign credit_used = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
    assign s_ready     = (credit_used < (CW+1)'(FIFO_DEPTH));

    assign acc     = s_valid & s_ready;
    assign capture = vld_sr[MUL_LATENCY-1];
    assign pop     = m_valid & m_ready;
    assign m_valid = (fifo_cnt != '0);

    // Core interface: operands are zeroed when nothing is accepted so the
    // core sees a quiet bus between transactions.
    assign mul_ena = 1'b1;
    assign mul_clr = ~rst_n;
    assign mul_ay  = acc ? s_a : ZERO;
    assign mul_az  = acc ? s_b : ZERO;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr       <= '0;
            inflight_cnt <= '0;
        end else begin
            vld_sr[0] <= acc;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
            case ({acc, capture})
                2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
                2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    fp_mul_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data (mul_result),
        .rd_en   (pop),
        .rd_data (m_result),
        .count   (fifo_cnt)
    );

endmodule : fp_mul_stream_ctrl

// File: tb/tb_fp_mul_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_mul_stream_ctrl
// Directed bench for fp_mul_stream_ctrl. A behavioural 4-stage multiplier core
// model drives mul_result; a scoreboard queue of expected products checks
// every popped result in order, alongside hand-computed directed values.
// -----------------------------------------------------------------------------
module tb_fp_mul_stream_ctrl;
    import fp_mul_stream_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic  clk;
    logic  rst_n;
    logic  s_valid;
    logic  s_ready;
    fp32_t s_a;
    fp32_t s_b;
    logic  m_valid;
    logic  m_ready;
    fp32_t m_result;
    logic  mul_ena;
    logic  mul_clr;
    fp32_t mul_ay;
    fp32_t mul_az;
    fp32_t mul_result;

    fp_mul_stream_ctrl #(
        .MUL_LATENCY (LAT),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_result   (m_result),
        .mul_ena    (mul_ena),
        .mul_clr    (mul_clr),
        .mul_ay     (mul_ay),
        .mul_az     (mul_az),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truncating FP32 multiply, exact for the normal operands used here.
    function automatic fp32_t fp_mul(input fp32_t a, input fp32_t b);
        logic        sgn;
        logic [47:0] p;
        logic [9:0]  e;
        sgn = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'h0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) return {sgn, e[7:0] + 8'd1, p[46:24]};
        return {sgn, e[7:0], p[45:23]};
    endfunction

    // Multiplier core model: LAT register stages, free running.
    fp32_t core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= fp_mul(mul_ay, mul_az);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign mul_result = core_pipe[LAT-1];

    int    total = 0;
    int    bad   = 0;
    int    stepn = 0;
    int    outstanding = 0;
    int    max_out = 0;
    logic  last_acc;
    logic  last_pop;
    fp32_t last_ay;
    fp32_t last_az;
    fp32_t exp_q [$];
    fp32_t got_q [$];
    int    acc_steps [$];
    int    pop_steps [$];

    fp32_t a3   [12] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                         32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                         32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
    fp32_t exp3 [12] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                         32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000,
                         32'h41900000, 32'h41A00000, 32'h41B00000, 32'h41C00000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes at the falling edge, score pops, record
    // accepts, then return just after the rising edge.
    task automatic step();
        fp32_t e;
        @(negedge clk);
        last_acc = s_valid && s_ready;
        last_pop = m_valid && m_ready;
        last_ay  = mul_ay;
        last_az  = mul_az;
        if (last_pop) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'bx;
            check("order", m_result, e);
            got_q.push_back(m_result);
            pop_steps.push_back(stepn);
            outstanding--;
        end
        if (last_acc) begin
            exp_q.push_back(fp_mul(s_a, s_b));
            acc_steps.push_back(stepn);
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
        end
        stepn++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        acc_steps.delete();
        pop_steps.delete();
    endtask

    function automatic fp32_t rand_fp();
        logic [7:0] ex;
        ex = 8'($urandom_range(154, 100));
        return {1'($urandom_range(1, 0)), ex, 23'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, idx, guard, wrong, sent, highs;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_a     = ZERO;
        s_b     = ZERO;
        m_ready = 1'b0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("clr_in_reset", mul_clr, 1'b1);
        @(posedge clk); #1;
        check("rst_s_ready", s_ready, 1'b1);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_result", m_result, ZERO);
        check("mul_ena", mul_ena, 1'b1);
        check("idle_mul_ay", mul_ay, ZERO);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("clr_after_reset", mul_clr, 1'b0);
        @(posedge clk); #1;

        // ---------------- 1: single op latency ----------------
        clear_logs();
        m_ready = 1'b1;
        s_valid = 1'b1; s_a = ONE; s_b = 32'h40000000;
        step();
        check("t1_accept", last_acc, 1'b1);
        check("t1_mul_ay", last_ay, ONE);
        check("t1_mul_az", last_az, 32'h40000000);
        s_valid = 1'b0; s_a = ZERO; s_b = ZERO;
        lat = 1;
        while (!m_valid && lat < 20) begin
            step();
            lat++;
        end
        check("t1_latency", lat, 5);
        check("t1_result", m_result, 32'h40000000);
        step();
        check("t1_single_beat", m_valid, 1'b0);
        check("t1_beats", got_q.size(), 1);

        // ---------------- 2: back-to-back stream ----------------
        clear_logs();
        s_valid = 1'b1; s_a = 32'h3FC00000; s_b = 32'h3FC00000;
        for (int i = 0; i < 100; i++) step();
        s_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("t2_accepts", acc_steps.size(), 100);
        check("t2_beats", got_q.size(), 100);
        wrong = 0;
        foreach (got_q[i]) if (got_q[i] !== 32'h40100000) wrong++;
        check("t2_values", wrong, 0);
        check("t2_first_latency", pop_steps[0] - acc_steps[0], 5);
        check("t2_consecutive", pop_steps[99] - pop_steps[0], 99);

        // ---------------- 3: backpressure ----------------
        clear_logs();
        m_ready = 1'b0;
        s_valid = 1'b1; s_b = 32'h40000000;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            s_a = a3[idx];
            step();
            if (last_acc) idx++;
        end
        check("t3_accepted", idx, 8);
        check("t3_s_ready_low", s_ready, 1'b0);
        check("t3_m_valid", m_valid, 1'b1);
        check("t3_head", m_result, 32'h40000000);
        step();
        check("t3_hold", m_result, 32'h40000000);

        // ---------------- 4: pop while full ----------------
        m_ready = 1'b1;
        s_a = a3[idx];
        step();
        check("t4_pop_done", last_pop, 1'b1);
        check("t4_no_same_cycle_accept", last_acc, 1'b0);
        check("t4_ready_next_cycle", s_ready, 1'b1);
        guard = 0;
        while (idx < 12 && guard < 40) begin
            s_a = a3[idx];
            step();
            if (last_acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        guard = 0;
        while (got_q.size() < 12 && guard < 40) begin
            step();
            guard++;
        end
        check("t3_total_beats", got_q.size(), 12);
        for (int i = 0; i < 12; i++) check($sformatf("t3_beat%0d", i), got_q[i], exp3[i]);

        // ---------------- 5: reset mid-flight ----------------
        clear_logs();
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_a = rand_fp(); s_b = rand_fp();
            step();
        end
        check("t5_accepts", acc_steps.size(), 3);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_clr", mul_clr, 1'b1);
        @(posedge clk); #1;
        check("t5_s_ready", s_ready, 1'b1);
        check("t5_m_valid", m_valid, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        outstanding = 0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (m_valid !== 1'b0) highs++;
        end
        check("t5_no_stale_beats", highs, 0);

        // ---------------- 6: random backpressure ----------------
        clear_logs();
        sent = 0;
        guard = 0;
        s_valid = 1'b1; s_a = rand_fp(); s_b = rand_fp();
        while (sent < 1000 && guard < 5000) begin
            m_ready = 1'($urandom_range(1, 0));
            step();
            if (last_acc) begin
                sent++;
                s_a = rand_fp(); s_b = rand_fp();
            end
            guard++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            step();
            guard++;
        end
        check("t6_sent", sent, 1000);
        check("t6_drained", exp_q.size(), 0);
        check("t6_beats", got_q.size(), 1000);
        check("occupancy_le_depth", (max_out <= DEPTH), 1'b1);
        check("occupancy_reaches_depth", max_out, DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fp_mul_stream_ctrl
